// File: rtl/fde_datapath_pkg.sv
// Shared definitions for the fetch/decode/execute datapath: default
// geometry, ALU and forwarding encodings, instruction field positions.
package fde_datapath_pkg;

    localparam int WIDTH_DEF            = 16;
    localparam int REGNUM_DEF           = 16;
    localparam int ADDRESSWIDTH_DEF     = 4;
    localparam int OPCODEWIDTH_DEF      = 4;
    localparam int INSTRUCTIONWIDTH_DEF = 24;

    // Instruction field positions (MSB of each field).
    localparam int OPCODE_MSB = 23;
    localparam int RD_MSB     = 19;
    localparam int RS1_MSB    = 15;
    localparam int RS2_MSB    = 11;

    // The immediate is the low 12 bits, sign-extended.
    localparam int IMM_BITS   = 12;

    // Shift amount is taken from the low bits of operand B.
    localparam int SHAMT_BITS = 4;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SHL  = 3'b101,
        ALU_SHR  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_WB   = 2'b01,
        FWD_M    = 2'b10,
        FWD_REG2 = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/fde_alu.sv
// Execute-stage ALU with NZVC flags. Purely combinational.
module fde_alu
    import fde_datapath_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             n_o,
    output logic             z_o,
    output logic             v_o,
    output logic             c_o
);

    logic [WIDTH:0]          sum_w;
    logic [WIDTH:0]          diff_w;
    logic [SHAMT_BITS-1:0]   shamt_w;

    // One extra bit on the adders captures the carry-out.
    assign sum_w   = {1'b0, a_i} + {1'b0, b_i};
    // Subtraction as A + ~B + 1 so that carry-out means "no borrow".
    assign diff_w  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt_w = b_i[SHAMT_BITS-1:0];

    // Operation select plus carry/overflow; logic ops leave C and V clear.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
        result_o = '0;
        c_o      = 1'b0;
        v_o      = 1'b0;
        unique case (op_i)
            ALU_ADD: begin
                result_o = sum_w[WIDTH-1:0];
                c_o      = sum_w[WIDTH];
                v_o      = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                           (sum_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                result_o = diff_w[WIDTH-1:0];
                c_o      = diff_w[WIDTH];
                v_o      = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                           (diff_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SHL:  result_o = a_i << shamt_w;
            ALU_SHR:  result_o = a_i >> shamt_w;
            ALU_PASS: result_o = b_i;
            default:  result_o = '0;
        endcase
    end

    assign n_o = result_o[WIDTH-1];
    assign z_o = (result_o == '0);

endmodule

// File: rtl/fde_datapath.sv
// Fetch PC, decode (field split, register file, immediate) and execute
// (forwarding, operand select, ALU) for the 5-stage pipeline.
module fde_datapath
    import fde_datapath_pkg::*;
#(
    parameter int WIDTH            = WIDTH_DEF,
    parameter int REGNUM           = REGNUM_DEF,
    parameter int ADDRESSWIDTH     = ADDRESSWIDTH_DEF,
    parameter int OPCODEWIDTH      = OPCODEWIDTH_DEF,
    parameter int INSTRUCTIONWIDTH = INSTRUCTIONWIDTH_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    // Fetch
    input  logic [WIDTH-1:0]            new_pc,
    input  logic                        take_branch,
    input  logic                        pc_enable,
    output logic [WIDTH-1:0]            pc,
    // Decode
    input  logic [INSTRUCTIONWIDTH-1:0] instruction,
    input  logic [WIDTH-1:0]            pc_d,
    input  logic                        pc_as_r1,
    input  logic                        wb_enable,
    input  logic [ADDRESSWIDTH-1:0]     wb_addr,
    input  logic [WIDTH-1:0]            wb_data,
    output logic [WIDTH-1:0]            reg1_data,
    output logic [WIDTH-1:0]            reg2_data,
    output logic [WIDTH-1:0]            immediate,
    output logic [ADDRESSWIDTH-1:0]     rd_addr,
    output logic [ADDRESSWIDTH-1:0]     rs1_addr,
    output logic [ADDRESSWIDTH-1:0]     rs2_addr,
    output logic [OPCODEWIDTH-1:0]      opcode,
    // Execute
    input  logic [WIDTH-1:0]            e_reg1,
    input  logic [WIDTH-1:0]            e_reg2,
    input  logic [WIDTH-1:0]            e_imm,
    input  logic [WIDTH-1:0]            fwd_m,
    input  logic [WIDTH-1:0]            fwd_wb,
    input  logic [2:0]                  alu_control,
    input  logic                        data2_sel,
    input  logic [1:0]                  fwd1_sel,
    input  logic [1:0]                  fwd2_sel,
    output logic [WIDTH-1:0]            reg2_final,
    output logic [WIDTH-1:0]            alu_out,
    output logic                        n,
    output logic                        z,
    output logic                        v,
    output logic                        c
);

    // ------------------------------------------------------------------
    // Fetch
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fetch_pc_q;
    logic [WIDTH-1:0] fetch_pc_d;

    // Next PC: a branch wins over a stall; otherwise step by one word.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (take_branch) begin
            fetch_pc_d = new_pc;
        end else if (pc_enable) begin
            fetch_pc_d = fetch_pc_q + WIDTH'(1);
        end
    end

    // PC register, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            fetch_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign pc = fetch_pc_q;

    // ------------------------------------------------------------------
    // Decode: field split and immediate
    // ------------------------------------------------------------------
    assign opcode   = instruction[OPCODE_MSB -: OPCODEWIDTH];
    assign rd_addr  = instruction[RD_MSB     -: ADDRESSWIDTH];
    assign rs1_addr = instruction[RS1_MSB    -: ADDRESSWIDTH];
    assign rs2_addr = instruction[RS2_MSB    -: ADDRESSWIDTH];

    assign immediate = {{(WIDTH-IMM_BITS){instruction[IMM_BITS-1]}},
                        instruction[IMM_BITS-1:0]};

    // ------------------------------------------------------------------
    // Decode: register file
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs_q [REGNUM];
    logic [WIDTH-1:0] rf_rd1;
    logic [WIDTH-1:0] rf_rd2;

    // Register array write port; every entry, r0 included, is ordinary.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: this array is reset on purpose (clears to zero), so it stays in flops rather than RAM.
        if (reset) begin
            for (int i = 0; i < REGNUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_enable) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Read ports with write-through so WB and decode can share a cycle.
    always_comb begin
        rf_rd1 = regs_q[rs1_addr];
        rf_rd2 = regs_q[rs2_addr];
        if (wb_enable && (wb_addr == rs1_addr)) begin
            rf_rd1 = wb_data;
        end
        if (wb_enable && (wb_addr == rs2_addr)) begin
            rf_rd2 = wb_data;
        end
    end

    assign reg1_data = pc_as_r1 ? pc_d : rf_rd1;
    assign reg2_data = rf_rd2;

    // ------------------------------------------------------------------
    // Execute: forwarding and operand select
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] fwd_reg2;

    // Forwarding muxes; both "register" encodings pick the pipeline operand.
    always_comb begin
        unique case (fwd_sel_e'(fwd1_sel))
            FWD_WB:  op_a = fwd_wb;
            FWD_M:   op_a = fwd_m;
            default: op_a = e_reg1;
        endcase
        unique case (fwd_sel_e'(fwd2_sel))
            FWD_WB:  fwd_reg2 = fwd_wb;
            FWD_M:   fwd_reg2 = fwd_m;
            default: fwd_reg2 = e_reg2;
        endcase
    end

    assign reg2_final = fwd_reg2;
    assign op_b       = data2_sel ? e_imm : fwd_reg2;

    fde_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .op_i     (alu_op_e'(alu_control)),
        .result_o (alu_out),
        .n_o      (n),
        .z_o      (z),
        .v_o      (v),
        .c_o      (c)
    );

endmodule

// File: tb/tb_fde_datapath.sv
// Directed bench for fde_datapath: hand sequences for fetch and register
// file, a vector table for the execute stage.
module tb_fde_datapath;

    logic        clock;
    logic        reset;
    logic [15:0] new_pc;
    logic        take_branch;
    logic        pc_enable;
    logic [15:0] pc;
    logic [23:0] instruction;
    logic [15:0] pc_d;
    logic        pc_as_r1;
    logic        wb_enable;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] reg1_data, reg2_data, immediate;
    logic [3:0]  rd_addr, rs1_addr, rs2_addr;
    logic [3:0]  opcode;
    logic [15:0] e_reg1, e_reg2, e_imm, fwd_m, fwd_wb;
    logic [2:0]  alu_control;
    logic        data2_sel;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic [15:0] reg2_final, alu_out;
    logic        n, z, v, c;

    int total = 0;
    int bad   = 0;

    fde_datapath dut (
        .clock       (clock),
        .reset       (reset),
        .new_pc      (new_pc),
        .take_branch (take_branch),
        .pc_enable   (pc_enable),
        .pc          (pc),
        .instruction (instruction),
        .pc_d        (pc_d),
        .pc_as_r1    (pc_as_r1),
        .wb_enable   (wb_enable),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .reg1_data   (reg1_data),
        .reg2_data   (reg2_data),
        .immediate   (immediate),
        .rd_addr     (rd_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .opcode      (opcode),
        .e_reg1      (e_reg1),
        .e_reg2      (e_reg2),
        .e_imm       (e_imm),
        .fwd_m       (fwd_m),
        .fwd_wb      (fwd_wb),
        .alu_control (alu_control),
        .data2_sel   (data2_sel),
        .fwd1_sel    (fwd1_sel),
        .fwd2_sel    (fwd2_sel),
        .reg2_final  (reg2_final),
        .alu_out     (alu_out),
        .n           (n),
        .z           (z),
        .v           (v),
        .c           (c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        d2;
        logic [2:0]  op;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] imm;
        logic [15:0] fm;
        logic [15:0] fw;
        logic [15:0] exp_out;
        logic [15:0] exp_r2f;
        logic [3:0]  exp_nzvc;
    } alu_vec_t;

    alu_vec_t vecs[15];

    initial begin
        // name, f1, f2, d2, op, e_reg1, e_reg2, e_imm, fwd_m, fwd_wb, out, reg2_final, nzvc
        vecs[0]  = '{"add_ovf",   2'b00, 2'b00, 1'b0, 3'b000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0001, 4'b1010};
        vecs[1]  = '{"sub_eq",    2'b00, 2'b00, 1'b0, 3'b001, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 4'b0101};
        vecs[2]  = '{"sub_neg",   2'b00, 2'b00, 1'b0, 3'b001, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 16'h0005, 4'b1000};
        vecs[3]  = '{"fwd_m_wb",  2'b10, 2'b01, 1'b0, 3'b000, 16'h0100, 16'h0200, 16'h0000, 16'h0002, 16'h0003, 16'h0005, 16'h0003, 4'b0000};
        vecs[4]  = '{"imm_sel",   2'b00, 2'b00, 1'b1, 3'b000, 16'h0002, 16'h9999, 16'h0010, 16'h0000, 16'h0000, 16'h0012, 16'h9999, 4'b0000};
        vecs[5]  = '{"and",       2'b00, 2'b00, 1'b0, 3'b010, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 16'h0000, 16'h3030, 16'h3C3C, 4'b0000};
        vecs[6]  = '{"or",        2'b00, 2'b00, 1'b0, 3'b011, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0F0F, 4'b1000};
        vecs[7]  = '{"xor",       2'b00, 2'b00, 1'b0, 3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hAAAA, 4'b0100};
        vecs[8]  = '{"shl",       2'b00, 2'b00, 1'b0, 3'b101, 16'h0001, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 16'h0013, 4'b0000};
        vecs[9]  = '{"shr",       2'b00, 2'b00, 1'b0, 3'b110, 16'h8000, 16'h000F, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h000F, 4'b0000};
        vecs[10] = '{"pass_b",    2'b00, 2'b00, 1'b0, 3'b111, 16'h1234, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 4'b1000};
        vecs[11] = '{"add_carry", 2'b00, 2'b00, 1'b0, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 4'b0101};
        vecs[12] = '{"fwd_11",    2'b11, 2'b11, 1'b0, 3'b001, 16'h0004, 16'h0001, 16'h0000, 16'h0100, 16'h0200, 16'h0003, 16'h0001, 4'b0001};
        vecs[13] = '{"sub_ovf",   2'b00, 2'b00, 1'b0, 3'b001, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0001, 4'b0011};
        vecs[14] = '{"add_ovf_c", 2'b00, 2'b00, 1'b0, 3'b000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 4'b0111};

        reset       = 1'b1;
        new_pc      = '0;
        take_branch = 1'b0;
        pc_enable   = 1'b0;
        instruction = '0;
        pc_d        = '0;
        pc_as_r1    = 1'b0;
        wb_enable   = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        e_reg1      = '0;
        e_reg2      = '0;
        e_imm       = '0;
        fwd_m       = '0;
        fwd_wb      = '0;
        alu_control = '0;
        data2_sel   = 1'b0;
        fwd1_sel    = '0;
        fwd2_sel    = '0;

        #12;
        reset = 1'b0;
        tick();
        check("pc_after_reset", pc, 16'h0000);

        // Dirty the state so a later reset has something to clear.
        pc_enable = 1'b1;
        wb_enable = 1'b1;
        wb_addr   = 4'd2;
        wb_data   = 16'hAAAA;
        tick();
        tick();
        wb_enable = 1'b0;
        check("pc_before_midreset", pc, 16'h0002);

        // Mid-cycle asynchronous reset.
        #2;
        reset       = 1'b1;
        pc_enable   = 1'b0;
        instruction = 24'h002200;   // rs1 = 2, rs2 = 2
        #1;
        check("pc_async_reset", pc, 16'h0000);
        check("r2_cleared_rd1", reg1_data, 16'h0000);
        check("r2_cleared_rd2", reg2_data, 16'h0000);
        #1;
        reset = 1'b0;

        pc_enable = 1'b1;
        tick();
        tick();
        tick();
        check("pc_count3", pc, 16'h0003);
        pc_enable = 1'b0;
        tick();
        tick();
        check("pc_hold", pc, 16'h0003);

        // Branch while stalled, then branch while enabled.
        take_branch = 1'b1;
        new_pc      = 16'h0040;
        tick();
        check("pc_branch_stall", pc, 16'h0040);
        pc_enable = 1'b1;
        new_pc    = 16'hFFFF;
        tick();
        check("pc_branch_enabled", pc, 16'hFFFF);
        take_branch = 1'b0;
        tick();
        check("pc_wrap", pc, 16'h0000);
        pc_enable = 1'b0;

        // Register file write then read.
        wb_enable = 1'b1;
        wb_addr   = 4'd5;
        wb_data   = 16'h1234;
        tick();
        wb_enable   = 1'b0;
        instruction = 24'h005000;
        #1;
        check("rf_r5_read", reg1_data, 16'h1234);

        // Write-through on port 2 while port 1 reads another register.
        wb_enable   = 1'b1;
        wb_addr     = 4'd7;
        wb_data     = 16'hBEEF;
        instruction = 24'h005700;
        #1;
        check("rf_bypass_rd2", reg2_data, 16'hBEEF);
        check("rf_no_bypass_rd1", reg1_data, 16'h1234);
        tick();
        wb_enable = 1'b0;
        #1;
        check("rf_r7_stored", reg2_data, 16'hBEEF);

        // r0 is an ordinary register.
        wb_enable = 1'b1;
        wb_addr   = 4'd0;
        wb_data   = 16'h0042;
        tick();
        wb_enable   = 1'b0;
        instruction = 24'h000000;
        #1;
        check("rf_r0_writable", reg1_data, 16'h0042);

        // PC substituted for reg1.
        pc_as_r1    = 1'b1;
        pc_d        = 16'h0010;
        instruction = 24'h005000;
        #1;
        check("pc_as_r1", reg1_data, 16'h0010);
        pc_as_r1 = 1'b0;

        // Decode field split and immediate.
        instruction = 24'h1A3FFE;
        #1;
        check("dec_opcode", opcode, 4'h1);
        check("dec_rd", rd_addr, 4'hA);
        check("dec_rs1", rs1_addr, 4'h3);
        check("dec_rs2", rs2_addr, 4'hF);
        check("dec_imm_neg", immediate, 16'hFFFE);
        instruction = 24'h0007FF;
        #1;
        check("dec_imm_pos", immediate, 16'h07FF);

        // Execute stage vectors.
        for (int i = 0; i < 15; i++) begin
            fwd1_sel    = vecs[i].f1;
            fwd2_sel    = vecs[i].f2;
            data2_sel   = vecs[i].d2;
            alu_control = vecs[i].op;
            e_reg1      = vecs[i].r1;
            e_reg2      = vecs[i].r2;
            e_imm       = vecs[i].imm;
            fwd_m       = vecs[i].fm;
            fwd_wb      = vecs[i].fw;
            #2;
            check({vecs[i].name, "_out"}, alu_out, vecs[i].exp_out);
            check({vecs[i].name, "_r2f"}, reg2_final, vecs[i].exp_r2f);
            check({vecs[i].name, "_nzvc"}, {n, z, v, c}, vecs[i].exp_nzvc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
